// File: rtl/alu_exec_unit.sv
// DLX execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle logic/arithmetic ops; SLL shifts one bit per cycle to stay small.
module alu_exec_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         alu_ctr,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               ovf,
   output logic               busy
);

   localparam logic [2:0] OpAnd  = 3'b000;
   localparam logic [2:0] OpOr   = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpSlt  = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpSll  = 3'b101;
   localparam logic [2:0] OpSub  = 3'b110;
   localparam logic [2:0] OpSltu = 3'b111;

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e               state_q;
   logic [WIDTH-1:0]     shift_q;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]     result_q;
   logic                 zero_q;
   logic                 ovf_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic [WIDTH-1:0]     sum;
   logic [WIDTH-1:0]     diff;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ovf;
   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     shift_next;
   logic                 accept;
   logic                 multi_cycle;

   assign shamt       = b[SHAMT_W-1:0];
   assign sum         = a + b;
   assign diff        = a - b;
   assign shift_next  = shift_q << 1;
   assign in_ready    = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept      = in_valid && in_ready;
   assign multi_cycle = (alu_ctr == OpSll) && (shamt != '0);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (alu_ctr)
         OpAnd:  alu_res = a & b;
         OpOr:   alu_res = a | b;
         OpAdd: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OpXor:  alu_res = a ^ b;
         // Only reached here with a zero shift amount; nonzero shifts go iterative.
         OpSll:  alu_res = a;
         OpSub: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (multi_cycle) begin
                     // in_ready guaranteed any pending result drains on this edge.
                     shift_q     <= a;
                     cnt_q       <= shamt;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b1;
                     state_q     <= StShift;
                  end else begin
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     ovf_q       <= alu_ovf;
                     out_valid_q <= 1'b1;
                  end
               end else if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            StShift: begin
               shift_q <= shift_next;
               cnt_q   <= cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  result_q    <= shift_next;
                  zero_q      <= (shift_next == '0);
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and model-checked bench for alu_exec_unit.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_ctr;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   logic        busy;

   int n_vec  = 0;
   int n_fail = 0;

   logic [31:0] q_res[$];
   logic        q_ovf[$];

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctr   (alu_ctr),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .busy      (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] x,
                                         input logic [31:0] y);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (c)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
         3'd3: r = {31'd0, ($signed(x) < $signed(y))};
         3'd4: r = x ^ y;
         3'd5: r = x << y[4:0];
         3'd6: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
         default: r = {31'd0, (x < y)};
      endcase
      return {v, r};
   endfunction

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_ctr = 3'd0; a = '0; b = '0;
      tick(); tick();
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || zero !== 1'b0 ||
          ovf !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: ov=%b busy=%b res=%h z=%b ovf=%b rdy=%b, required 0 0 0 0 0 1",
                  out_valid, busy, result, zero, ovf, in_ready);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add_ovf;
      in_valid = 1'b1; alu_ctr = 3'd2; a = 32'h7FFF_FFFF; b = 32'd1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ovf: ov=%b res=%h ovf=%b z=%b, required 1 80000000 1 0",
                  out_valid, result, ovf, zero);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      in_valid = 1'b1; out_ready = 1'b1;
      alu_ctr = 3'd6; a = 32'd5; b = 32'd5;
      tick();
      alu_ctr = 3'd7; a = 32'd1; b = 32'hFFFF_FFFF;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_sub: ov=%b res=%h z=%b ovf=%b, required 1 0 1 0",
                  out_valid, result, zero, ovf);
      end
      tick();
      alu_ctr = 3'd3;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd1 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_sltu: ov=%b res=%h z=%b, required 1 1 0", out_valid, result, zero);
      end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_slt: ov=%b res=%h z=%b, required 1 0 1", out_valid, result, zero);
      end
      tick();
   endtask

   task automatic test_ops;
      logic [2:0]  t_c[9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd6, 3'd3, 3'd7, 3'd2};
      logic [31:0] t_a[9] = '{32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA,
                              32'h8000_0000, 32'd3, 32'h8000_0000, 32'h8000_0000,
                              32'h8000_0000};
      logic [31:0] t_b[9] = '{32'hFF00_FF00, 32'h0000_00F0, 32'd1, 32'hFFFF_FFFF, 32'd1,
                              32'd5, 32'd1, 32'd1, 32'h8000_0000};
      logic [31:0] t_r[9] = '{32'hF000_F000, 32'h0F0F_00F0, 32'd0, 32'h5555_5555,
                              32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0};
      logic        t_v[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; alu_ctr = t_c[i]; a = t_a[i]; b = t_b[i];
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || result !== t_r[i] || ovf !== t_v[i] ||
             zero !== (t_r[i] == 32'd0)) begin
            n_fail++;
            $display("FAIL op%0d: ov=%b res=%h ovf=%b z=%b, required 1 %h %b %b", i,
                     out_valid, result, ovf, zero, t_r[i], t_v[i], (t_r[i] == 32'd0));
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_sll;
      out_ready = 1'b1;
      in_valid = 1'b1; alu_ctr = 3'd5; a = 32'h0000_0003; b = 32'd4;
      tick();
      in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'd9;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sll_busy%0d: busy=%b rdy=%b ov=%b, required 1 0 0", i,
                     busy, in_ready, out_valid);
         end
         tick();
      end
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'h30 || busy !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL sll_done: ov=%b res=%h busy=%b ovf=%b, required 1 00000030 0 0",
                  out_valid, result, busy, ovf);
      end
      in_valid = 1'b1; alu_ctr = 3'd5; a = 32'h0000_ABCD; b = 32'hFFFF_FFE0;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'h0000_ABCD || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sll_zero: ov=%b res=%h busy=%b, required 1 0000abcd 0",
                  out_valid, result, busy);
      end
      tick();
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_valid = 1'b1; alu_ctr = 3'd0; a = 32'hFF; b = 32'h0F;
      tick();
      alu_ctr = 3'd1; a = 32'd1; b = 32'd2;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0F) begin
            n_fail++;
            $display("FAIL bp_hold%0d: ov=%b rdy=%b res=%h, required 1 0 0000000f", i,
                     out_valid, in_ready, result);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready: in_ready=%b, required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'd3) begin
         n_fail++;
         $display("FAIL bp_reload: ov=%b res=%h, required 1 00000003", out_valid, result);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_shift;
      out_ready = 1'b1;
      in_valid = 1'b1; alu_ctr = 3'd5; a = 32'd1; b = 32'd31;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_vec++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midshift_busy: busy=%b, required 1", busy);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
         n_fail++;
         $display("FAIL midshift_reset: ov=%b busy=%b res=%h, required 0 0 0",
                  out_valid, busy, result);
      end
      tick();
      reset = 1'b0;
      in_valid = 1'b1; alu_ctr = 3'd1; a = 32'hF0; b = 32'h0F;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 32'hFF || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_or: ov=%b res=%h busy=%b, required 1 000000ff 0",
                  out_valid, result, busy);
      end
      tick();
   endtask

   task automatic test_random;
      int          accepted;
      int          cycles;
      logic [32:0] m;
      logic [31:0] er;
      logic        ev;
      accepted = 0;
      cycles   = 0;
      while ((accepted < 150 || q_res.size() != 0) && cycles < 20000) begin
         in_valid  = (accepted < 150) && ($urandom_range(0, 3) != 0);
         alu_ctr   = 3'($urandom_range(0, 7));
         a         = $urandom;
         b         = $urandom;
         if (alu_ctr == 3'd5) b[4:0] = 5'($urandom_range(0, 6));
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (out_valid && out_ready) begin
            n_vec++;
            if (q_res.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra: res=%h with no pending op", result);
            end else begin
               er = q_res.pop_front();
               ev = q_ovf.pop_front();
               if (result !== er || ovf !== ev || zero !== (er == 32'd0)) begin
                  n_fail++;
                  $display("FAIL rand_out: res=%h ovf=%b z=%b, required %h %b %b",
                           result, ovf, zero, er, ev, (er == 32'd0));
               end
            end
         end
         if (in_valid && in_ready) begin
            m = model(alu_ctr, a, b);
            q_res.push_back(m[31:0]);
            q_ovf.push_back(m[32]);
            accepted++;
         end
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (q_res.size() != 0 || accepted != 150) begin
         n_fail++;
         $display("FAIL rand_complete: accepted=%0d pending=%0d, required 150 0",
                  accepted, q_res.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_back_to_back();
      test_ops();
      test_sll();
      test_backpressure();
      test_reset_mid_shift();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- DLX execute-stage ALU, directly downstream of the ALU control unit.
- Consumes the 3-bit ALUCtr code plus two WIDTH-bit operands and produces a registered result, zero flag and signed-overflow flag.
- Uses a valid/ready handshake on both sides.
- SLL is iterative, one bit per cycle, so the stage is area-cheap; all other ops complete in one cycle.

Parameters:
- WIDTH, 32: operand/result width.
- SHAMT_W, 5: width of the shift amount, taken from b[SHAMT_W-1:0]; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and ALUCtr valid
- in_ready  output  1  stage can accept an operation
- alu_ctr  input  3  operation code from the ALU control unit
- a  input  WIDTH  operand A (shift source for SLL)
- b  input  WIDTH  operand B (shift amount in low SHAMT_W bits for SLL)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- ovf  output  1  signed overflow; ADD/SUB only, else 0
- busy  output  1  SHIFT state active

Behaviour:
- Codes (fixed):
  - 000 AND, 001 OR, 010 ADD, 011 SLT (signed), 100 XOR, 101 SLL, 110 SUB, 111 SLTU (unsigned).
  - SLT/SLTU give result = {WIDTH-1 zeros, lt}.
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf is set when the operand signs satisfy the overflow condition and the result sign differs:
    - ADD: operand signs equal.
    - SUB: a and b signs differ.
- Reset (async, immediate): state=IDLE; out_valid=0, result=0, zero=0, ovf=0, busy=0, shift counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Purely combinational; no dependency on in_valid.
- Accept = in_valid && in_ready at a rising edge.
- Output handshake:
  - Output transfer = out_valid && out_ready.
  - result/zero/ovf hold stable while out_valid && !out_ready.
  - out_valid drops after a transfer edge unless a new result is loaded on the same edge, in which case it stays 1.
- States:
  - IDLE:
    - Accept of a non-SLL op, or SLL with shamt=0: compute combinationally and register result/zero/ovf on the accept edge. out_valid=1 in the next cycle (latency 1). State stays IDLE, so back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
    - Accept of SLL with shamt=k>0: load shift reg=a and counter=k, go to SHIFT, busy=1.
  - SHIFT:
    - Each edge: shift reg <<= 1 with zero fill, counter -= 1.
    - On the edge where counter goes 1->0: register result=shift value, zero from it, ovf=0, out_valid=1, return to IDLE.
    - Latency for k>0 is k+1 cycles from accept to out_valid.
    - in_ready=0 throughout.
    - In SHIFT out_valid is already 0, because in_ready at accept required any previous result to be draining that edge.
- Shift amounts >= WIDTH (when 2^SHAMT_W > WIDTH) give result 0 after k cycles.
- alu_ctr, a and b are sampled only at accept; changes afterwards are ignored.
- Reset asserted mid-SHIFT or with a pending output:
  - The operation is discarded; out_valid=0 immediately.
  - After reset release, the first accept behaves as from power-up.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 with out_ready=1: out_valid next cycle, result=0x80000000, ovf=1, zero=0.
- SUB a=5 b=5 then SLTU a=1 b=0xFFFFFFFF back-to-back, in_valid held: two consecutive out_valid cycles giving result=0/zero=1, then result=1; SLT with the same operands gives result=0.
- SLL a=0x00000003 b=4: busy 4 cycles, in_ready=0 meanwhile, out_valid 5 cycles after accept, result=0x30; SLL b=0 gives result=a in 1 cycle.
- Backpressure: AND result pending with out_ready=0 for 3 cycles: in_ready=0 and result stable. Raise out_ready with in_valid high: transfer and new accept on the same edge, with out_valid staying 1.
- Assert reset mid-SHIFT (SLL b=31, 10 cycles in): out_valid=0 and busy=0 immediately. Next op OR a=0xF0 b=0x0F returns 0xFF in 1 cycle.
- Random ops with a golden model under random out_ready: every accepted op produces exactly one output, in order, matching the model.
